// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// 8N1 serial receiver that feeds the command parser. It recovers one ASCII
// character per frame from the host RX line. Each good character appears on
// cmd, and rd strobes for one clock on the cycle after cmd changes. A frame
// whose stop bit reads low is dropped and flagged with frame_err, and never
// strobed.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate; CLKS_PER_BIT = CLK_FREQ / BAUD, must be >= 8
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts any frame in progress
//   rx         asynchronous serial line, idle high
//   cmd[7:0]   last correctly framed character, held until the next good one
//   rd         one-cycle strobe, one clock after cmd updates
//   busy       high whenever the receiver is not idle
//   frame_err  one-cycle pulse when a stop bit is sampled low
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       rd,
  output logic       busy,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    STROBE,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;

  logic cnt_clr;
  logic idx_clr;
  logic shift_en;
  logic load_cmd;
  logic ferr_set;
  logic bit_done;
  logic half_done;

  // Two-flop synchroniser; both stages reset high so that reset release
  // with an idle line does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  assign bit_done  = (bit_cnt == BIT_LAST);
  assign half_done = (bit_cnt == HALF_LAST);

  // The START check lands half a bit after the start edge. Every later
  // sample is a whole bit after the previous one, so all samples sit at
  // bit centres.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    shift_en   = 1'b0;
    load_cmd   = 1'b0;
    ferr_set   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (half_done) begin
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
            cnt_clr    = 1'b1;
            idx_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == 3'd7) next_state = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            load_cmd   = 1'b1;
            next_state = STROBE;
          end else begin
            ferr_set   = 1'b1;
            next_state = WAIT_IDLE;
          end
        end
      end
      STROBE:    next_state = IDLE;
      WAIT_IDLE: if (rx_s) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // rd is registered from the STROBE state, so it rises one clock after
  // cmd is loaded. The consumer therefore sees a settled cmd at the rd edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      sh        <= 8'h00;
      cmd       <= 8'h00;
      rd        <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_clr)             bit_cnt <= '0;
      else if (state != IDLE)  bit_cnt <= bit_cnt + CNT_W'(1);
      if (idx_clr)             bit_idx <= 3'd0;
      else if (shift_en)       bit_idx <= bit_idx + 3'd1;
      if (shift_en)            sh      <= {rx_s, sh[7:1]};
      if (load_cmd)            cmd     <= sh;
      rd        <= (state == STROBE);
      frame_err <= ferr_set;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
// Directed bench for uart_cmd_rx with CLKS_PER_BIT = 16. Frames are driven
// on falling edges. A monitor samples on falling edges and records every
// rd pulse with its cycle, the cmd value at the pulse and cmd one cycle
// earlier. It also counts frame_err pulses and any rd longer than a clock.
module tb_uart_cmd_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] cmd;
  logic       rd;
  logic       busy;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         rd_times[$];
  logic [7:0] rd_vals[$];
  logic [7:0] rd_pre[$];
  logic [7:0] prev_cmd = 8'h00;
  logic       prev_rd  = 1'b0;
  int         ferr_cnt = 0;
  int         rd_wide  = 0;
  int         last_start = 0;

  uart_cmd_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .cmd       (cmd),
    .rd        (rd),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records rd pulses and frame_err activity away from the active edge.
  always @(negedge clk) begin
    if (rd === 1'b1) begin
      rd_times.push_back(cyc);
      rd_vals.push_back(cmd);
      rd_pre.push_back(prev_cmd);
      if (prev_rd === 1'b1) rd_wide = rd_wide + 1;
    end
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    prev_cmd = cmd;
    prev_rd  = rd;
  end

  function automatic logic [31:0] rdTime(input int i);
    return (rd_times.size() > i) ? 32'(rd_times[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rdVal(input int i);
    return (rd_vals.size() > i) ? {24'h0, rd_vals[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rdPre(input int i);
    return (rd_pre.size() > i) ? {24'h0, rd_pre[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one full 10-bit frame starting at a falling edge. The first rising
  // edge that sees rx low is recorded in last_start.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    last_start = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int fbase;
    int starts[5];
    logic [7:0] stream[5];
    logic [7:0] bits55;

    stream[0] = 8'h66; stream[1] = 8'h31; stream[2] = 8'h32;
    stream[3] = 8'h33; stream[4] = 8'h34;

    // Reset held for three cycles with an idle line.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd",  {24'h0, cmd}, 32'h00);
    checkOutput("reset_rd",   {31'h0, rd}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_ferr", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    idle(10);

    // Single frame 'f'.
    base  = rd_times.size();
    fbase = ferr_cnt;
    applyStimulus(8'h66, 1'b1);
    idle(20);
    checkOutput("single_rd_count", 32'(rd_times.size() - base), 32'd1);
    checkOutput("single_rd_time",  rdTime(base), 32'(last_start + 155));
    checkOutput("single_rd_cmd",   rdVal(base), 32'h66);
    checkOutput("single_cmd_pre",  rdPre(base), 32'h66);
    checkOutput("single_ferr",     32'(ferr_cnt - fbase), 32'd0);
    checkOutput("single_busy",     {31'h0, busy}, 32'h0);

    // Back-to-back "f1234" with no idle gap.
    base = rd_times.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(stream[i], 1'b1);
      starts[i] = last_start;
    end
    idle(20);
    checkOutput("stream_rd_count", 32'(rd_times.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stream_cmd%0d", i), rdVal(base + i), {24'h0, stream[i]});
      checkOutput($sformatf("stream_time%0d", i), rdTime(base + i),
                  32'(starts[0] + 155 + 160 * i));
    end

    // Five-cycle glitch is rejected at the START check.
    base  = rd_times.size();
    last_start = cyc + 1;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    checkOutput("glitch_busy_high", {31'h0, busy}, 32'h1);
    idle(30);
    checkOutput("glitch_rd_count", 32'(rd_times.size() - base), 32'd0);
    checkOutput("glitch_busy_low", {31'h0, busy}, 32'h0);
    checkOutput("glitch_cmd",      {24'h0, cmd}, 32'h34);

    // Framing error: 0x41 with a low stop bit, then 40 more low cycles.
    base  = rd_times.size();
    fbase = ferr_cnt;
    applyStimulus(8'h41, 1'b0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("ferr_wait_busy", {31'h0, busy}, 32'h1);
    repeat (20) @(negedge clk);
    idle(20);
    checkOutput("ferr_count",    32'(ferr_cnt - fbase), 32'd1);
    checkOutput("ferr_rd_count", 32'(rd_times.size() - base), 32'd0);
    checkOutput("ferr_cmd",      {24'h0, cmd}, 32'h34);
    checkOutput("ferr_busy",     {31'h0, busy}, 32'h0);
    base = rd_times.size();
    applyStimulus(8'h42, 1'b1);
    idle(20);
    checkOutput("after_ferr_rd_count", 32'(rd_times.size() - base), 32'd1);
    checkOutput("after_ferr_cmd",      rdVal(base), 32'h42);

    // Reset during data bit 4 of 0x55.
    base  = rd_times.size();
    fbase = ferr_cnt;
    bits55 = 8'h55;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = bits55[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bits55[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(30);
    checkOutput("midrst_rd_count", 32'(rd_times.size() - base), 32'd0);
    checkOutput("midrst_cmd",      {24'h0, cmd}, 32'h00);
    checkOutput("midrst_ferr",     32'(ferr_cnt - fbase), 32'd0);
    checkOutput("midrst_busy",     {31'h0, busy}, 32'h0);
    base = rd_times.size();
    applyStimulus(8'h37, 1'b1);
    idle(20);
    checkOutput("post_rst_rd_count", 32'(rd_times.size() - base), 32'd1);
    checkOutput("post_rst_rd_cmd",   rdVal(base), 32'h37);
    checkOutput("post_rst_cmd",      {24'h0, cmd}, 32'h37);

    checkOutput("rd_single_cycle", 32'(rd_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
